// File: rtl/fsm_eg_stim_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : fsm_eg_stim_gen_pkg
// Brief  : Shared encodings, default step table and field helpers for the
//          fsm_eg stimulus sequencer and its golden model.
// Rev    : 1.0  initial release
// ============================================================================
package fsm_eg_stim_gen_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_DRIVE  = 2'd1,
    SEQ_FINISH = 2'd2
  } seq_state_e;

  // States of the fsm_eg device under stimulus
  typedef enum logic [1:0] {
    EG_S0 = 2'd0,
    EG_S1 = 2'd1,
    EG_S2 = 2'd2
  } eg_state_e;

  localparam int unsigned FSM_EG_DEF_STEPS  = 8;
  localparam int unsigned FSM_EG_DEF_HOLD_W = 4;

  // Default table, step 7 in the MSBs. Each step is {a, b, hold[3:0]}.
  localparam logic [47:0] FSM_EG_DEF_PATTERN = {
    6'b11_0001,  // step 7
    6'b00_0100,  // step 6
    6'b10_0000,  // step 5
    6'b01_0010,  // step 4
    6'b11_0000,  // step 3
    6'b10_0011,  // step 2
    6'b00_0001,  // step 1
    6'b11_0010   // step 0
  };

  // Field offsets inside one step relative to that step's LSB
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned hold_w);
    return idx * (hold_w + 2);
  endfunction

  function automatic int unsigned field_b_ofs(input int unsigned hold_w);
    return hold_w;
  endfunction

  function automatic int unsigned field_a_ofs(input int unsigned hold_w);
    return hold_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_eg_stim_gen_model.sv
`default_nettype none
// ============================================================================
// Module : fsm_eg_stim_gen_model
// Brief  : Golden three-state fsm_eg model (Mealy y0, Moore yl), used as the
//          response reference by the stimulus sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module fsm_eg_stim_gen_model
  import fsm_eg_stim_gen_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_i,
  input  logic b_i,
  output logic y0_o,
  output logic yl_o
);

  eg_state_e state_q, state_d;

  // State register, returns to S0 on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EG_S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Transitions plus Mealy y0 (S0 with a&b) and Moore yl (S1/S2)
  always_comb begin
    state_d = state_q;
    y0_o    = 1'b0;
    yl_o    = 1'b0;
    case (state_q)
      EG_S0: begin
        if (a_i && b_i) begin
          state_d = EG_S2;
          y0_o    = 1'b1;
        end else if (a_i) begin
          state_d = EG_S1;
        end
      end
      EG_S1: begin
        yl_o = 1'b1;
        if (a_i) begin
          state_d = EG_S0;
        end
      end
      EG_S2: begin
        yl_o    = 1'b1;
        state_d = EG_S0;
      end
      default: state_d = EG_S0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fsm_eg_stim_gen.sv
`default_nettype none
// ============================================================================
// Module : fsm_eg_stim_gen
// Brief  : Table-driven stimulus sequencer for fsm_eg. Plays a packed step
//          table onto registered a/b, counts y0/yl pulses per run and,
//          when FSM_EG_CHECK_EN is defined, checks responses against a
//          golden fsm_eg model.
// Macro  : FSM_EG_CHECK_EN - enables the response checker
// Rev    : 1.0  initial release
// ============================================================================
module fsm_eg_stim_gen
  import fsm_eg_stim_gen_pkg::*;
#(
  parameter int unsigned                     NUM_STEPS = FSM_EG_DEF_STEPS,
  parameter int unsigned                     HOLD_W    = FSM_EG_DEF_HOLD_W,
  parameter logic [NUM_STEPS*(HOLD_W+2)-1:0] PATTERN   = FSM_EG_DEF_PATTERN
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       y0_i,
  input  logic       yl_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] step_idx_o,
  output logic [7:0] y0_cnt_o,
  output logic [7:0] yl_cnt_o,
  output logic       mismatch_o,
  output logic [3:0] err_step_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_STEPS - 1);

  // Unpacked view of the table, padded to 16 entries so a 4-bit index
  // always lands on a defined entry
  logic [HOLD_W-1:0] tbl_hold [16];
  logic              tbl_a    [16];
  logic              tbl_b    [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_tbl
    if (gi < NUM_STEPS) begin : g_used
      localparam int unsigned LSB = field_lsb(gi, HOLD_W);
      assign tbl_hold[gi] = PATTERN[LSB +: HOLD_W];
      assign tbl_a[gi]    = PATTERN[LSB + field_a_ofs(HOLD_W)];
      assign tbl_b[gi]    = PATTERN[LSB + field_b_ofs(HOLD_W)];
    end else begin : g_unused
      assign tbl_hold[gi] = '0;
      assign tbl_a[gi]    = 1'b0;
      assign tbl_b[gi]    = 1'b0;
    end
  end

  seq_state_e        state_q,    state_d;
  logic              a_q,        a_d;
  logic              b_q,        b_d;
  logic [3:0]        step_idx_q, step_idx_d;
  logic [HOLD_W-1:0] hold_q,     hold_d;
  logic [7:0]        y0_cnt_q,   y0_cnt_d;
  logic [7:0]        yl_cnt_q,   yl_cnt_d;
  logic              mismatch_q, mismatch_d;
  logic [3:0]        err_step_q, err_step_d;

  // High when the sampled response differs from the golden model
  logic resp_diff;

`ifdef FSM_EG_CHECK_EN
  logic model_y0;
  logic model_yl;

  // The model sees exactly the registered a/b the real device sees
  fsm_eg_stim_gen_model u_model (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_i    (a_q),
    .b_i    (b_q),
    .y0_o   (model_y0),
    .yl_o   (model_yl)
  );

  assign resp_diff = (y0_i != model_y0) || (yl_i != model_yl);
`else
  assign resp_diff = 1'b0;
`endif

  // Sequencer registers, all cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SEQ_IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      step_idx_q <= 4'd0;
      hold_q     <= '0;
      y0_cnt_q   <= 8'd0;
      yl_cnt_q   <= 8'd0;
      mismatch_q <= 1'b0;
      err_step_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      step_idx_q <= step_idx_d;
      hold_q     <= hold_d;
      y0_cnt_q   <= y0_cnt_d;
      yl_cnt_q   <= yl_cnt_d;
      mismatch_q <= mismatch_d;
      err_step_q <= err_step_d;
    end
  end

  // Next-state: start acceptance, step advance, counting and checking
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    step_idx_d = step_idx_q;
    hold_d     = hold_q;
    y0_cnt_d   = y0_cnt_q;
    yl_cnt_d   = yl_cnt_q;
    mismatch_d = mismatch_q;
    err_step_d = err_step_q;
    case (state_q)
      SEQ_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start_i) begin
          state_d    = SEQ_DRIVE;
          step_idx_d = 4'd0;
          hold_d     = tbl_hold[0];
          a_d        = tbl_a[0];
          b_d        = tbl_b[0];
          y0_cnt_d   = 8'd0;
          yl_cnt_d   = 8'd0;
          mismatch_d = 1'b0;
          err_step_d = 4'd0;
        end
      end
      SEQ_DRIVE: begin
        if (y0_i && (y0_cnt_q != 8'hFF)) begin
          y0_cnt_d = y0_cnt_q + 8'd1;
        end
        if (yl_i && (yl_cnt_q != 8'hFF)) begin
          yl_cnt_d = yl_cnt_q + 8'd1;
        end
        if (resp_diff) begin
          mismatch_d = 1'b1;
          if (!mismatch_q) begin
            err_step_d = step_idx_q;
          end
        end
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (step_idx_q == LAST_IDX) begin
          state_d = SEQ_FINISH;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          step_idx_d = step_idx_q + 4'd1;
          hold_d     = tbl_hold[step_idx_q + 4'd1];
          a_d        = tbl_a[step_idx_q + 4'd1];
          b_d        = tbl_b[step_idx_q + 4'd1];
        end
      end
      SEQ_FINISH: begin
        state_d = SEQ_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: begin
        state_d = SEQ_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy_o     = (state_q == SEQ_DRIVE);
  assign done_o     = (state_q == SEQ_FINISH);
  assign step_idx_o = step_idx_q;
  assign y0_cnt_o   = y0_cnt_q;
  assign yl_cnt_o   = yl_cnt_q;
  assign mismatch_o = mismatch_q;
  assign err_step_o = err_step_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_eg_stim_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_fsm_eg_stim_gen
// Brief  : Scoreboard bench for fsm_eg_stim_gen. A two-step instance is run
//          with random timing, response faults, held start and mid-run
//          resets; a sixteen-step instance exercises counter saturation.
// Macro  : FSM_EG_CHECK_EN - expectations follow the checker build
// Rev    : 1.0  initial release
// ============================================================================
module tb_fsm_eg_stim_gen;

  // Basic table: step0 {a=1,b=1,hold=1}, step1 {a=0,b=0,hold=0}
  localparam logic [7:0]  B_PAT = 8'b0000_1101;
  // Saturation table: sixteen steps of {a=1,b=0,hold=15}
  localparam logic [95:0] S_PAT = {16{6'b10_1111}};
`ifdef FSM_EG_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  int step_a [2] = '{1, 0};
  int step_b [2] = '{1, 0};
  int step_h [2] = '{1, 0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start, y0, yl, a, b, busy, done, mm;
  logic [3:0] sidx, es;
  logic [7:0] c0, cl;
  logic       s_start, s_y0, s_yl, s_a, s_b, s_busy, s_done, s_mm;
  logic [3:0] s_sidx, s_es;
  logic [7:0] s_c0, s_cl;

  fsm_eg_stim_gen #(.NUM_STEPS(2), .HOLD_W(2), .PATTERN(B_PAT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .y0_i(y0), .yl_i(yl),
    .a_o(a), .b_o(b), .busy_o(busy), .done_o(done), .step_idx_o(sidx),
    .y0_cnt_o(c0), .yl_cnt_o(cl), .mismatch_o(mm), .err_step_o(es));

  fsm_eg_stim_gen #(.NUM_STEPS(16), .HOLD_W(4), .PATTERN(S_PAT)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .y0_i(s_y0), .yl_i(s_yl),
    .a_o(s_a), .b_o(s_b), .busy_o(s_busy), .done_o(s_done), .step_idx_o(s_sidx),
    .y0_cnt_o(s_c0), .yl_cnt_o(s_cl), .mismatch_o(s_mm), .err_step_o(s_es));

  typedef struct packed {
    logic       a;
    logic       b;
    logic [3:0] st;
    logic       y0;
    logic       yl;
  } cyc_t;

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] cl;
    logic       mm;
    logic [3:0] es;
  } run_t;

  cyc_t cyc_q [$];
  run_t run_q [$];
  int   plant_s = 0;   // fsm_eg state (0,1,2) as the real device would hold it
  int   n_cmp   = 0;
  int   n_bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the table, derive device responses, inject faults,
  // and queue per-cycle and per-run expectations
  task automatic build_run(input int pct, input int fstep, output int tot);
    int s, e0, el, ees;
    bit emm;
    s = plant_s; e0 = 0; el = 0; ees = 0; emm = 1'b0; tot = 0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k <= step_h[i]; k++) begin
        bit ta, tb, ty0, tyl, f0, f1;
        cyc_t c;
        ta  = (step_a[i] != 0);
        tb  = (step_b[i] != 0);
        ty0 = (s == 0) && ta && tb;
        tyl = (s != 0);
        f0  = ($urandom_range(99) < pct);
        f1  = ($urandom_range(99) < pct) || (i == fstep);
        c.a = ta; c.b = tb; c.st = 4'(i); c.y0 = ty0 ^ f0; c.yl = tyl ^ f1;
        if (c.y0 && e0 < 255) e0++;
        if (c.yl && el < 255) el++;
        if (CHK != 0 && (f0 || f1)) begin
          if (!emm) ees = i;
          emm = 1'b1;
        end
        cyc_q.push_back(c);
        tot++;
        if (s == 0)      s = (ta && tb) ? 2 : (ta ? 1 : 0);
        else if (s == 1) s = ta ? 0 : 1;
        else             s = 0;
      end
    end
    if (s == 2) s = 0;   // the a=b=0 FINISH cycle leaves S2
    plant_s = s;
    run_q.push_back({8'(e0), 8'(el), emm, 4'(ees)});
  endtask

  // Monitor: plays the device responses and checks against the scoreboard
  always @(negedge clk) begin : mon
    cyc_t c;
    run_t r;
    if (rst_n) begin
      if (busy) begin
        if (cyc_q.size() == 0) begin
          check("unexpected_busy", int'(busy), 0);
          y0 = 1'b0; yl = 1'b0;
        end else begin
          c = cyc_q.pop_front();
          check("a_o", int'(a), int'(c.a));
          check("b_o", int'(b), int'(c.b));
          check("step_idx", int'(sidx), int'(c.st));
          y0 = c.y0; yl = c.yl;
        end
      end else begin
        y0 = 1'b0; yl = 1'b0;
      end
      if (done) begin
        if (run_q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          r = run_q.pop_front();
          check("y0_cnt", int'(c0), int'(r.c0));
          check("yl_cnt", int'(cl), int'(r.cl));
          check("mismatch", int'(mm), int'(r.mm));
          check("err_step", int'(es), int'(r.es));
          check("done_ab_low", int'(a | b), 0);
        end
      end
    end
  end

  task automatic run_basic(input int pct, input bit poke, input int fstep, input int gap);
    int tot, lat;
    build_run(pct, fstep, tot);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (done) begin lat = cyc; break; end
      start = poke && (cyc == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_latency", lat, tot + 1);
    repeat (5 + gap) @(negedge clk);
  endtask

  task automatic run_held();
    int t1, t2, d1, d2;
    build_run(0, -1, t1);
    build_run(0, -1, t2);
    d1 = 0; d2 = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (done) begin
        if (d1 == 0) d1 = cyc;
        else if (d2 == 0) d2 = cyc;
      end
      if (cyc == t1 + 3) start = 1'b0;
      if (d2 != 0) break;
      @(negedge clk);
    end
    start = 1'b0;
    check("held_done1", d1, t1 + 1);
    check("held_done2", d2, t1 + t2 + 3);
    repeat (5) @(negedge clk);
  endtask

  task automatic reset_mid();
    int tot;
    build_run(0, -1, tot);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_y0_cnt", int'(c0), 0);
    check("rst_step", int'(sidx), 0);
    cyc_q.delete();
    run_q.delete();
    plant_s = 0;
    y0 = 1'b0; yl = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_basic(0, 1'b0, -1, 0);
  endtask

  task automatic run_sat();
    int lat;
    lat = 0;
    s_y0 = 1'b0; s_yl = 1'b1;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == 200) check("sat_mid_yl_cnt", int'(s_cl), 199);
      if (s_done) begin lat = cyc; break; end
      @(negedge clk);
    end
    check("sat_latency", lat, 257);
    check("sat_yl_cnt", int'(s_cl), 255);
    check("sat_y0_cnt", int'(s_c0), 0);
    check("sat_mismatch", int'(s_mm), CHK);
    check("sat_err_step", int'(s_es), 0);
    s_yl = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    start = 1'b0; y0 = 1'b0; yl = 1'b0;
    s_start = 1'b0; s_y0 = 1'b0; s_yl = 1'b0;
    #1 rst_n = 1'b0;
    // Reset held while start toggles and responses are active
    repeat (3) begin
      @(negedge clk);
      start = ~start; s_start = ~s_start; yl = 1'b1; s_y0 = 1'b1;
    end
    @(negedge clk);
    check("reset_a", int'(a), 0);
    check("reset_b", int'(b), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_yl_cnt", int'(cl), 0);
    check("reset_mismatch", int'(mm), 0);
    check("reset_sat_busy", int'(s_busy), 0);
    check("reset_sat_y0_cnt", int'(s_c0), 0);
    start = 1'b0; s_start = 1'b0; yl = 1'b0; s_y0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    run_basic(0, 1'b0, -1, 0);    // basic run
    run_basic(0, 1'b1, -1, 0);    // start while busy
    run_basic(0, 1'b0, 1, 0);     // response fault in step 1
    check("mismatch_hold", int'(mm), CHK);
    check("err_step_hold", int'(es), CHK);
    run_basic(0, 1'b0, -1, 0);    // clean run clears the flag
    run_held();
    reset_mid();
    run_sat();

    for (int it = 0; it < 24; it++) begin
      int sel;
      sel = $urandom_range(9);
      if (sel == 0)      run_held();
      else if (sel == 1) reset_mid();
      else run_basic((sel > 5) ? 30 : 0, 1'($urandom_range(1)), -1, $urandom_range(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
